cc_cond_unit: RTL and testbench
===============================

Name: cc_cond_unit

Overview:
- Consumer side of the 64-bit ALU's condition-code output.
- Latches the ALU's 3-bit CC vector (ZF SF OF) into the architectural condition-code register.
- Evaluates the Y86-64 condition selected by ifun for jXX/cmovXX against the held flags.
- Registers the resulting Cnd and valE into the execute-to-memory boundary, with stall/bubble control, so the same block serves SEQ and the later PIPE build.

Parameters:
- W, 64, datapath width of valE pass-through.
- CC_RESET, 3'b100, CC register reset value {ZF,SF,OF} (ZF=1, SF=0, OF=0).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising clk edge.
- e_valid  input  1  execute stage holds a real instruction this cycle.
- set_cc  input  1  instruction is OPq; commit alu_cc into CC register.
- alu_cc  input  3  ALU flags {ZF,SF,OF} = bit2,bit1,bit0.
- cond_use  input  1  instruction is jXX or cmovXX; ifun is a condition code.
- ifun  input  4  condition selector.
- e_valE  input  W  ALU result to forward.
- exc_pending  input  1  a later stage holds an exception (m_stat/W_stat not AOK); suppress CC commit.
- stall  input  1  hold output registers and CC.
- bubble  input  1  inject a bubble into output registers.
- cc  output  3  current CC register {ZF,SF,OF}.
- e_cnd  output  1  combinational condition result for the current instruction.
- M_cnd  output  1  registered Cnd.
- M_valE  output  W  registered valE.
- M_valid  output  1  registered valid.
- ill_cond  output  1  sticky: illegal condition seen.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - cc=CC_RESET, M_cnd=0, M_valE=0, M_valid=0, ill_cond=0.
  - Reset overrides stall and bubble and any in-flight update.
- CC register update:
  - cc <= alu_cc when set_cc & e_valid & ~stall & ~exc_pending & rst_n; otherwise cc holds.
  - New flags are visible on cc the cycle after commit.
- e_cnd is combinational from the current cc register value, i.e. the pre-update value in the same cycle as a set_cc. Let X = SF^OF:
  - ifun 0 (always): 1
  - ifun 1 (le): X|ZF
  - ifun 2 (l): X
  - ifun 3 (e): ZF
  - ifun 4 (ne): ~ZF
  - ifun 5 (ge): ~X
  - ifun 6 (g): ~X & ~ZF
  - ifun 7-15: 0
- e_cnd forcing:
  - e_cnd is forced to 0 when ~e_valid.
  - When ~cond_use, e_cnd follows the ifun table above; downstream ignores it.
- Output register priority: rst_n > stall > bubble > load.
  - stall=1: M_cnd, M_valE and M_valid hold. stall wins when stall and bubble are both 1.
  - bubble=1, stall=0: M_valid=0, M_cnd=0, M_valE=0.
  - Otherwise: M_cnd<=e_cnd, M_valE<=e_valE, M_valid<=e_valid.
  - Latency from e_* inputs to M_* outputs is exactly one cycle.
- ill_cond:
  - Set when e_valid & cond_use & ifun>6 & ~stall.
  - Once set, cleared only by reset.
- No other state is kept; the datapath is pure pass-through, with no arithmetic on valE.

Test Plan:
- Reset: rst_n=0 for 2 cycles with stall=1, bubble=1 -> cc=3'b100, M_valid=0, M_valE=0, M_cnd=0, ill_cond=0.
- CC commit timing: set_cc=1, e_valid=1, alu_cc=3'b011, ifun=2 -> same cycle e_cnd=0 (old cc=100, X=0); next cycle cc=011 and ifun=2 gives e_cnd=0 (X=1^1=0); alu_cc=3'b010 committed, then ifun=2 -> e_cnd=1, ifun=5 -> 0.
- Full condition sweep: for each cc in {000,001,010,011,100,110} and ifun 0..6 -> e_cnd matches the table; e.g. cc=100: le=1, l=0, e=1, ne=0, ge=1, g=0.
- Exception suppression: exc_pending=1, set_cc=1, alu_cc=3'b001 -> cc unchanged; de-assert exc_pending -> commits the next cycle.
- Stall/bubble: load e_valE=64'h3C, e_valid=1; then stall=1, bubble=1 with e_valE=64'h5 -> M_valE stays 64'h3C, M_valid=1; then stall=0, bubble=1 -> M_valid=0, M_valE=0; and cc does not change while stall=1 even with set_cc=1.
- Illegal condition: cond_use=1, e_valid=1, ifun=4'h9 -> e_cnd=0; ill_cond=1 next cycle and remains 1 after legal traffic until rst_n=0 is applied.

Source files
------------

// File: rtl/cc_cond_unit.sv
// Execute-stage condition-code unit: holds the Y86-64 CC register, evaluates
// jXX/cmovXX conditions against it, and registers Cnd/valE into the E->M boundary.
module cc_cond_unit #(
    parameter int          W        = 64,
    parameter logic [2:0]  CC_RESET = 3'b100
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         e_valid,
    input  logic         set_cc,
    input  logic [2:0]   alu_cc,
    input  logic         cond_use,
    input  logic [3:0]   ifun,
    input  logic [W-1:0] e_valE,
    input  logic         exc_pending,
    input  logic         stall,
    input  logic         bubble,
    output logic [2:0]   cc,
    output logic         e_cnd,
    output logic         M_cnd,
    output logic [W-1:0] M_valE,
    output logic         M_valid,
    output logic         ill_cond
);

    logic zf, sf, of, lt;
    logic cnd_raw;
    logic cc_commit;
    logic ill_seen;

    assign zf = cc[2];
    assign sf = cc[1];
    assign of = cc[0];
    assign lt = sf ^ of;

    // Conditions read the held flags, so a set_cc in this cycle is not yet visible.
    always_comb begin
        cnd_raw = 1'b0;
        case (ifun)
            4'd0:    cnd_raw = 1'b1;
            4'd1:    cnd_raw = lt | zf;
            4'd2:    cnd_raw = lt;
            4'd3:    cnd_raw = zf;
            4'd4:    cnd_raw = ~zf;
            4'd5:    cnd_raw = ~lt;
            4'd6:    cnd_raw = ~lt & ~zf;
            default: cnd_raw = 1'b0;
        endcase
    end

    assign e_cnd     = e_valid & cnd_raw;
    assign cc_commit = set_cc & e_valid & ~stall & ~exc_pending;
    assign ill_seen  = e_valid & cond_use & (ifun > 4'd6) & ~stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cc <= CC_RESET;
        end else if (cc_commit) begin
            cc <= alu_cc;
        end
    end

    // Stall takes priority over bubble so a held instruction is never dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            M_cnd   <= 1'b0;
            M_valE  <= '0;
            M_valid <= 1'b0;
        end else if (stall) begin
            M_cnd   <= M_cnd;
            M_valE  <= M_valE;
            M_valid <= M_valid;
        end else if (bubble) begin
            M_cnd   <= 1'b0;
            M_valE  <= '0;
            M_valid <= 1'b0;
        end else begin
            M_cnd   <= e_cnd;
            M_valE  <= e_valE;
            M_valid <= e_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ill_cond <= 1'b0;
        end else if (ill_seen) begin
            ill_cond <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cc_cond_unit.sv
// Self-checking bench for cc_cond_unit: directed scenarios plus random traffic,
// with expected M_* outputs queued at drive time and compared after the edge.
module tb_cc_cond_unit;
  localparam int W = 64;
  localparam logic [2:0] CC_RESET = 3'b100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         e_valid = 1'b0;
  logic         set_cc = 1'b0;
  logic [2:0]   alu_cc = 3'b000;
  logic         cond_use = 1'b0;
  logic [3:0]   ifun = 4'd0;
  logic [W-1:0] e_valE = '0;
  logic         exc_pending = 1'b0;
  logic         stall = 1'b0;
  logic         bubble = 1'b0;
  logic [2:0]   cc;
  logic         e_cnd;
  logic         M_cnd;
  logic [W-1:0] M_valE;
  logic         M_valid;
  logic         ill_cond;

  cc_cond_unit #(.W(W), .CC_RESET(CC_RESET)) dut (
    .clk(clk), .rst_n(rst_n), .e_valid(e_valid), .set_cc(set_cc),
    .alu_cc(alu_cc), .cond_use(cond_use), .ifun(ifun), .e_valE(e_valE),
    .exc_pending(exc_pending), .stall(stall), .bubble(bubble), .cc(cc),
    .e_cnd(e_cnd), .M_cnd(M_cnd), .M_valE(M_valE), .M_valid(M_valid),
    .ill_cond(ill_cond)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W+1:0] exp_q[$];

  logic [2:0]   m_cc = CC_RESET;
  logic         m_ill = 1'b0;
  logic         m_valid = 1'b0;
  logic         m_cnd = 1'b0;
  logic [W-1:0] m_valE = '0;
  bit           model_known = 1'b0;
  logic         s_ecnd;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic cond_model(input logic [2:0] flags, input logic [3:0] fn, input logic v);
    logic z, less;
    z    = flags[2];
    less = (flags[1] != flags[0]);
    if (!v) return 1'b0;
    case (fn)
      4'd0: return 1'b1;
      4'd1: return less || z;
      4'd2: return less;
      4'd3: return z;
      4'd4: return !z;
      4'd5: return !less;
      4'd6: return !less && !z;
      default: return 1'b0;
    endcase
  endfunction

  // One clock cycle of stimulus; checks e_cnd before the edge, registers after.
  task automatic cyc(input logic r, input logic v, input logic sc, input logic [2:0] ac,
                     input logic cu, input logic [3:0] fn, input logic [W-1:0] ve,
                     input logic ex, input logic st, input logic bb);
    logic exp_c;
    logic [W+1:0] e;
    rst_n = r; e_valid = v; set_cc = sc; alu_cc = ac; cond_use = cu;
    ifun = fn; e_valE = ve; exc_pending = ex; stall = st; bubble = bb;
    #1;
    s_ecnd = e_cnd;
    exp_c = cond_model(m_cc, fn, v);
    if (model_known) check("e_cnd", e_cnd, exp_c);
    if (!r) begin
      m_cc = CC_RESET; m_ill = 1'b0; m_valid = 1'b0; m_cnd = 1'b0; m_valE = '0;
      model_known = 1'b1;
    end else begin
      if (sc && v && !st && !ex) m_cc = ac;
      if (v && cu && fn > 4'd6 && !st) m_ill = 1'b1;
      if (!st) begin
        if (bb) begin
          m_valid = 1'b0; m_cnd = 1'b0; m_valE = '0;
        end else begin
          m_valid = v; m_cnd = exp_c; m_valE = ve;
        end
      end
    end
    exp_q.push_back({m_valid, m_cnd, m_valE});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("M_valid", M_valid, e[W+1]);
    check("M_cnd", M_cnd, e[W]);
    check("M_valE", M_valE, e[W-1:0]);
    check("cc", cc, m_cc);
    check("ill_cond", ill_cond, m_ill);
  endtask

  logic [2:0] ccs [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b110};
  logic [6:0] got100;

  initial begin
    // reset dominates stall and bubble
    cyc(0, 1, 1, 3'b011, 0, 4'd0, 64'h11, 0, 1, 1);
    cyc(0, 1, 1, 3'b011, 0, 4'd0, 64'h11, 0, 1, 1);
    check("rst_cc", cc, 3'b100);
    check("rst_valid", M_valid, 1'b0);
    check("rst_valE", M_valE, 64'h0);
    check("rst_ill", ill_cond, 1'b0);

    // commit timing: condition sees pre-update flags
    cyc(1, 1, 1, 3'b011, 1, 4'd2, 64'h1, 0, 0, 0);
    check("pre_commit_l", s_ecnd, 1'b0);
    check("commit_cc", cc, 3'b011);
    cyc(1, 1, 1, 3'b010, 1, 4'd2, 64'h2, 0, 0, 0);
    check("l_on_011", s_ecnd, 1'b0);
    cyc(1, 1, 0, 3'b000, 1, 4'd2, 64'h3, 0, 0, 0);
    check("l_on_010", s_ecnd, 1'b1);
    cyc(1, 1, 0, 3'b000, 1, 4'd5, 64'h4, 0, 0, 0);
    check("ge_on_010", s_ecnd, 1'b0);

    // exception suppresses the commit
    cyc(1, 1, 1, 3'b001, 0, 4'd0, 64'h5, 1, 0, 0);
    check("exc_hold", cc, 3'b010);
    cyc(1, 1, 1, 3'b001, 0, 4'd0, 64'h6, 0, 0, 0);
    check("exc_release", cc, 3'b001);

    // invalid slot forces e_cnd low
    cyc(1, 0, 0, 3'b000, 1, 4'd0, 64'h7, 0, 0, 0);
    check("invalid_cnd", s_ecnd, 1'b0);

    // condition sweep
    got100 = '0;
    foreach (ccs[k]) begin
      cyc(1, 1, 1, ccs[k], 0, 4'd0, 64'h10, 0, 0, 0);
      for (int f = 0; f < 7; f++) begin
        cyc(1, 1, 0, 3'b000, 1, 4'(f), 64'(f), 0, 0, 0);
        if (ccs[k] == 3'b100) got100[f] = s_ecnd;
      end
    end
    check("tbl_cc100", got100, 7'b0101011);

    // stall beats bubble; bubble clears
    cyc(1, 1, 0, 3'b000, 0, 4'd0, 64'h3C, 0, 0, 0);
    check("load_valE", M_valE, 64'h3C);
    cyc(1, 1, 1, 3'b001, 0, 4'd0, 64'h5, 0, 1, 1);
    check("stall_valE", M_valE, 64'h3C);
    check("stall_valid", M_valid, 1'b1);
    check("stall_cc", cc, 3'b110);
    cyc(1, 1, 0, 3'b000, 0, 4'd0, 64'h5, 0, 0, 1);
    check("bubble_valid", M_valid, 1'b0);
    check("bubble_valE", M_valE, 64'h0);

    // illegal condition is sticky
    cyc(1, 1, 0, 3'b000, 1, 4'h9, 64'h9, 0, 0, 0);
    check("ill_cnd", s_ecnd, 1'b0);
    check("ill_set", ill_cond, 1'b1);
    cyc(1, 1, 0, 3'b000, 1, 4'd3, 64'hA, 0, 0, 0);
    cyc(1, 1, 1, 3'b100, 1, 4'd0, 64'hB, 0, 0, 0);
    check("ill_sticky", ill_cond, 1'b1);

    // random traffic
    for (int i = 0; i < 80; i++) begin
      cyc(1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 9)), {$urandom, $urandom},
          1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0),
          1'($urandom_range(0, 4) == 0));
    end

    cyc(0, 1, 1, 3'b011, 1, 4'h9, 64'h1, 0, 1, 1);
    check("final_rst_ill", ill_cond, 1'b0);
    check("final_rst_cc", cc, 3'b100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
